// File: rtl/c17_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c17_pipe_pkg
// Brief    : Shared constants and the c17 reference function for the pipe.
// Revision : 1.0 - initial release
// ============================================================================
package c17_pipe_pkg;

  localparam int BASE_LEVELS = 3;

  function automatic int lat(input int extra);
    return BASE_LEVELS + extra;
  endfunction

  // Returns {n22, n23} for one lane.
  function automatic logic [1:0] c17_ref(input logic n1, input logic n2,
                                         input logic n3, input logic n6,
                                         input logic n7);
    logic nand36;
    nand36 = ~(n3 & n6);
    return {(n1 & n3) | (n2 & nand36), nand36 & (n2 | n7)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/c17_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : c17_delay_line
// Brief    : DEPTH-stage flop chain with async reset and sync clear;
//            DEPTH=0 is a pure passthrough.
// Revision : 1.0 - initial release
// ============================================================================
module c17_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk ^ rst ^ clr;
      assign q         = d;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/c17_balanced_pipe.sv
`default_nettype none
// ============================================================================
// Module   : c17_balanced_pipe
// Brief    : Path-balanced, registered-per-level multi-lane c17 pipeline
//            with valid chain, in-flight counter and flush.
//            Optional self-checker enabled by macro C17_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module c17_balanced_pipe
  import c17_pipe_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int EXTRA_STAGES = 0,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_n1,
  input  logic [LANES-1:0] in_n2,
  input  logic [LANES-1:0] in_n3,
  input  logic [LANES-1:0] in_n6,
  input  logic [LANES-1:0] in_n7,
  output logic             out_valid,
  output logic [LANES-1:0] out_n22,
  output logic [LANES-1:0] out_n23,
  output logic [CNT_W-1:0] inflight,
  output logic             idle
`ifdef C17_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int LAT = lat(EXTRA_STAGES);

  // Level 1 gates plus the N2 balancing flop.
  logic [LANES-1:0] a_q, b_q, c_q, n2_q;
  // Level 2 gate plus balancing flops for a, b, c.
  logic [LANES-1:0] d_q, a2_q, b2_q, c2_q;
  // Level 3 gates.
  logic [LANES-1:0] n22_q, n23_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      n2_q  <= '0;
      d_q   <= '0;
      a2_q  <= '0;
      b2_q  <= '0;
      c2_q  <= '0;
      n22_q <= '0;
      n23_q <= '0;
    end else begin
      a_q   <= in_n1 & in_n3;
      b_q   <= in_n3 & in_n6;
      c_q   <= in_n2 | in_n7;
      n2_q  <= in_n2;
      d_q   <= n2_q & ~b_q;
      a2_q  <= a_q;
      b2_q  <= b_q;
      c2_q  <= c_q;
      n22_q <= a2_q | d_q;
      n23_q <= ~b2_q & c2_q;
    end
  end

  c17_delay_line #(
    .WIDTH(2*LANES),
    .DEPTH(EXTRA_STAGES)
  ) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   ({n22_q, n23_q}),
    .q   ({out_n22, out_n23})
  );

  // A token offered on a flush edge is dropped, so it never enters the chain.
  c17_delay_line #(
    .WIDTH(1),
    .DEPTH(LAT)
  ) u_valid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .d   (in_valid & ~flush),
    .q   (out_valid)
  );

  logic [CNT_W-1:0] inflight_q, inflight_d;

  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (in_valid && !out_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!in_valid && out_valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0);

`ifdef C17_CHECK_EN
  localparam int REF_W = 5*LANES + 1;

  logic [REF_W-1:0] ref_tail;
  logic [LANES-1:0] exp_n22, exp_n23;
  logic             mismatch;
  logic             chk_err_q, chk_err_d;

  c17_delay_line #(
    .WIDTH(REF_W),
    .DEPTH(LAT)
  ) u_ref (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   ({in_valid, in_n1, in_n2, in_n3, in_n6, in_n7}),
    .q   (ref_tail)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_ref_lane
    assign {exp_n22[i], exp_n23[i]} = c17_ref(ref_tail[4*LANES+i],
                                              ref_tail[3*LANES+i],
                                              ref_tail[2*LANES+i],
                                              ref_tail[LANES+i],
                                              ref_tail[i]);
  end

  assign mismatch  = out_valid & ref_tail[REF_W-1] &
                     ((exp_n22 != out_n22) | (exp_n23 != out_n23));
  assign chk_err_d = chk_err_q | mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c17_balanced_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_c17_balanced_pipe
// Brief    : Self-checking bench for c17_balanced_pipe (EXTRA_STAGES 0 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_c17_balanced_pipe;
  import c17_pipe_pkg::*;

  logic       clk, rst, flush, in_valid;
  logic [3:0] in_n1, in_n2, in_n3, in_n6, in_n7;

  logic       ov0, idle0, ov2, idle2;
  logic [3:0] n22_0, n23_0, inf0, n22_2, n23_2, inf2;
`ifdef C17_CHECK_EN
  logic       err0, err2;
`endif

  c17_balanced_pipe #(.LANES(4), .EXTRA_STAGES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_n1(in_n1), .in_n2(in_n2), .in_n3(in_n3), .in_n6(in_n6), .in_n7(in_n7),
    .out_valid(ov0), .out_n22(n22_0), .out_n23(n23_0),
    .inflight(inf0), .idle(idle0)
`ifdef C17_CHECK_EN
    , .chk_err(err0)
`endif
  );

  c17_balanced_pipe #(.LANES(4), .EXTRA_STAGES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_n1(in_n1), .in_n2(in_n2), .in_n3(in_n3), .in_n6(in_n6), .in_n7(in_n7),
    .out_valid(ov2), .out_n22(n22_2), .out_n23(n23_2),
    .inflight(inf2), .idle(idle2)
`ifdef C17_CHECK_EN
    , .chk_err(err2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] n1, n2, n3, n6, n7;
    logic [3:0] e22, e23;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Edge history: a token accepted at edge a is alive while no clear happened
  // at or after a, and shows on the outputs right after edge a+LAT-1.
  int         t = 0;
  int         last_clr = 0;
  logic       acc_h [0:1023];
  logic [3:0] h1 [0:1023];
  logic [3:0] h2 [0:1023];
  logic [3:0] h3 [0:1023];
  logic [3:0] h6 [0:1023];
  logic [3:0] h7 [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, t);
  endtask

  task automatic chk_model(input int L, input string nm, input logic ov,
                           input logic [3:0] o22, input logic [3:0] o23,
                           input logic [3:0] infl, input logic idl);
    int         cnt;
    int         idx;
    logic       ev;
    logic [1:0] r;
    logic [3:0] e22, e23;
    cnt = 0; idx = 0; ev = 1'b0; e22 = '0; e23 = '0;
    for (int a = t - L + 1; a <= t; a++) begin
      if (a >= 1 && a > last_clr && acc_h[a]) begin
        cnt++;
        if (a == t - L + 1) begin ev = 1'b1; idx = a; end
      end
    end
    chk({nm, ".out_valid"}, 32'(ov), 32'(ev));
    chk({nm, ".inflight"}, 32'(infl), 32'(cnt));
    chk({nm, ".idle"}, 32'(idl), 32'(cnt == 0));
    if (ev) begin
      for (int i = 0; i < 4; i++) begin
        r = c17_ref(h1[idx][i], h2[idx][i], h3[idx][i], h6[idx][i], h7[idx][i]);
        e22[i] = r[1];
        e23[i] = r[0];
      end
      chk({nm, ".out_n22"}, 32'(o22), 32'(e22));
      chk({nm, ".out_n23"}, 32'(o23), 32'(e23));
    end
  endtask

  task automatic step(input logic v, input logic f, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [3:0] a3,
                      input logic [3:0] a6, input logic [3:0] a7);
    in_valid = v; flush = f;
    in_n1 = a1; in_n2 = a2; in_n3 = a3; in_n6 = a6; in_n7 = a7;
    @(posedge clk);
    t++;
    acc_h[t] = v & ~f;
    h1[t] = a1; h2[t] = a2; h3[t] = a3; h6[t] = a6; h7[t] = a7;
    if (f) last_clr = t;
    #1;
    chk_model(3, "lat3", ov0, n22_0, n23_0, inf0, idle0);
    chk_model(5, "lat5", ov2, n22_2, n23_2, inf2, idle2);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic rand_step(input logic v, input logic f);
    step(v, f, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".ov0"}, 32'(ov0), 32'h0);
    chk({nm, ".n22_0"}, 32'(n22_0), 32'h0);
    chk({nm, ".n23_0"}, 32'(n23_0), 32'h0);
    chk({nm, ".inf0"}, 32'(inf0), 32'h0);
    chk({nm, ".idle0"}, 32'(idle0), 32'h1);
    chk({nm, ".ov2"}, 32'(ov2), 32'h0);
    chk({nm, ".n22_2"}, 32'(n22_2), 32'h0);
    chk({nm, ".n23_2"}, 32'(n23_2), 32'h0);
    chk({nm, ".inf2"}, 32'(inf2), 32'h0);
    chk({nm, ".idle2"}, 32'(idle2), 32'h1);
  endtask

  vec_t vecs [6];
  int   seen0, seen2;
  int   peak;

  initial begin
    vecs[0] = '{n1:4'hF, n2:4'hF, n3:4'hF, n6:4'hF, n7:4'hF, e22:4'hF, e23:4'h0};
    vecs[1] = '{n1:4'h0, n2:4'hF, n3:4'h5, n6:4'h5, n7:4'h0, e22:4'hA, e23:4'hA};
    vecs[2] = '{n1:4'h0, n2:4'h0, n3:4'h0, n6:4'h0, n7:4'h0, e22:4'h0, e23:4'h0};
    vecs[3] = '{n1:4'h0, n2:4'h0, n3:4'h0, n6:4'h0, n7:4'hF, e22:4'h0, e23:4'hF};
    vecs[4] = '{n1:4'hF, n2:4'h0, n3:4'hF, n6:4'h0, n7:4'h0, e22:4'hF, e23:4'h0};
    vecs[5] = '{n1:4'h3, n2:4'hC, n3:4'h6, n6:4'hA, n7:4'h1, e22:4'hE, e23:4'hD};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_n1 = '0; in_n2 = '0; in_n3 = '0; in_n6 = '0; in_n7 = '0;
    #3;
    chk_reset_state("reset");
    #9 rst = 1'b0;

    // Single tokens from the table, drained through the 3-level pipe.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, vecs[i].n1, vecs[i].n2, vecs[i].n3, vecs[i].n6, vecs[i].n7);
      if (i == 0) chk("single.inflight1", 32'(inf0), 32'd1);
      idle_step();
      if (i == 0) chk("single.inflight2", 32'(inf0), 32'd1);
      idle_step();
      chk($sformatf("table%0d.valid", i), 32'(ov0), 32'h1);
      chk($sformatf("table%0d.n22", i), 32'(n22_0), 32'(vecs[i].e22));
      chk($sformatf("table%0d.n23", i), 32'(n23_0), 32'(vecs[i].e23));
      if (i == 0) chk("single.inflight3", 32'(inf0), 32'd1);
      idle_step();
      if (i == 0) chk("single.inflight4", 32'(inf0), 32'd0);
    end
    repeat (3) idle_step();

    // Back-to-back random stream; the deeper pipe must peak at 5 tokens.
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      rand_step(1'b1, 1'b0);
      if (int'(inf2) > peak) peak = int'(inf2);
    end
    for (int i = 0; i < 6; i++) begin
      idle_step();
      if (int'(inf2) > peak) peak = int'(inf2);
    end
    chk("stream.peak", 32'(peak), 32'd5);
    chk("stream.drained", 32'(inf2), 32'd0);

    // Flush on the third edge of a four-token burst: only the last survives.
    rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b1);
    chk("flush.inf0", 32'(inf0), 32'd0);
    chk("flush.inf2", 32'(inf2), 32'd0);
    seen0 = 0; seen2 = 0;
    rand_step(1'b1, 1'b0);
    seen0 += int'(ov0); seen2 += int'(ov2);
    for (int i = 0; i < 7; i++) begin
      idle_step();
      seen0 += int'(ov0); seen2 += int'(ov2);
    end
    chk("flush.emerged0", 32'(seen0), 32'd1);
    chk("flush.emerged2", 32'(seen2), 32'd1);

    // Asynchronous reset mid-burst, released before the next edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("prerst.ov0", 32'(ov0), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    last_clr = t;
    #2 rst = 1'b0;
    step(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    idle_step();
    chk("postrst.early", 32'(ov0), 32'h0);
    idle_step();
    chk("postrst.ov0", 32'(ov0), 32'h1);
    chk("postrst.n22", 32'(n22_0), 32'hF);
    repeat (4) idle_step();

    // Random soak with sparse valids and occasional flushes.
    for (int i = 0; i < 80; i++) begin
      rand_step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    repeat (6) idle_step();
    chk("final.idle0", 32'(idle0), 32'h1);
    chk("final.idle2", 32'(idle2), 32'h1);

`ifdef C17_CHECK_EN
    chk("chk_err0", 32'(err0), 32'h0);
    chk("chk_err2", 32'(err2), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
